// File: rtl/sensor_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sensor_stream_pkg
// Brief    : Shared constants and FSM encodings for the sensor frame transmitter.
// Revision : 1.0 - initial release
// ============================================================================
package sensor_stream_pkg;

    localparam int WORDS_PER_FRAME = 163;
    localparam int DATA_W          = 32;
    localparam int FIFO_AW         = 9;
    localparam int EMPTY_W         = 2;
    localparam int DROP_CNT_W      = 16;
    localparam int BEAT_CNT_W      = $clog2(WORDS_PER_FRAME);
    // Enough to count every whole frame the FIFO can hold (3 at the default size).
    localparam int FRAME_CNT_W     = 3;

    typedef enum logic [0:0] {
        ING_WAIT    = 1'b0,
        ING_COLLECT = 1'b1
    } ingest_state_e;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_LOAD = 2'd1,
        TX_SEND = 2'd2
    } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/sensor_frame_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : sensor_frame_tx_if
// Brief    : Readout input side plus Avalon-ST source side of the frame link.
// Revision : 1.0 - initial release
// ============================================================================
interface sensor_frame_tx_if;
    import sensor_stream_pkg::*;

    logic                 in_frame_start;
    logic                 in_valid;
    logic [DATA_W-1:0]    in_data;

    logic [DATA_W-1:0]    out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_startofpacket;
    logic                 out_endofpacket;
    logic [EMPTY_W-1:0]   out_empty;

    // master: readout front-end and stream sink; slave: the frame transmitter
    modport master (
        output in_frame_start, in_valid, in_data, out_ready,
        input  out_data, out_valid, out_startofpacket, out_endofpacket, out_empty
    );

    modport slave (
        input  in_frame_start, in_valid, in_data, out_ready,
        output out_data, out_valid, out_startofpacket, out_endofpacket, out_empty
    );

endinterface
`default_nettype wire

// File: rtl/sensor_frame_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sensor_frame_fifo
// Brief    : Simple dual-port RAM (1 write, 1 registered read) with pointers and fill level.
// Revision : 1.0 - initial release
// ============================================================================
module sensor_frame_fifo #(
    parameter int DATA_W = 32,
    parameter int AW     = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic [AW:0]       level_o
);

    logic [DATA_W-1:0] mem_q [0:(1<<AW)-1];
    logic [DATA_W-1:0] rd_data_q;
    logic [AW:0]       wr_ptr_q;
    logic [AW:0]       rd_ptr_q;

    // RAM array and its read register carry no reset so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_ptr_q[AW-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_en_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    assign rd_data_o = rd_data_q;
    assign level_o   = wr_ptr_q - rd_ptr_q;

endmodule
`default_nettype wire

// File: rtl/sensor_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : sensor_frame_tx
// Brief    : Buffers whole readout frames and sends each as one Avalon-ST packet.
//            Build option INVERT_DATA_EN: output words are bit-inverted.
// Revision : 1.0 - initial release
// ============================================================================
module sensor_frame_tx
    import sensor_stream_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    sensor_frame_tx_if.slave      bus,
    output logic [DROP_CNT_W-1:0] frame_drop_cnt,
    output logic                  proto_err,
    output logic                  busy
);

    localparam logic [FIFO_AW:0]      c_DEPTH       = (FIFO_AW+1)'(2**FIFO_AW);
    localparam logic [FIFO_AW:0]      c_FRAME_WORDS = (FIFO_AW+1)'(WORDS_PER_FRAME);
    localparam logic [BEAT_CNT_W-1:0] c_LAST_BEAT   = BEAT_CNT_W'(WORDS_PER_FRAME-1);

    ingest_state_e          ing_state_q, ing_state_d;
    tx_state_e              tx_state_q, tx_state_d;
    logic [BEAT_CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [BEAT_CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
    logic [FRAME_CNT_W-1:0] frames_ready_q, frames_ready_d;
    logic [DROP_CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic                   proto_err_q, proto_err_d;

    logic                   w_wr_en;
    logic                   w_rd_en;
    logic                   w_frame_done;
    logic                   w_eop_accept;
    logic                   w_fits;
    logic [FIFO_AW:0]       w_level;
    logic [FIFO_AW:0]       w_free;
    logic [DATA_W-1:0]      w_rd_data;
    logic [DATA_W-1:0]      w_word;

    sensor_frame_fifo #(
        .DATA_W (DATA_W),
        .AW     (FIFO_AW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (w_wr_en),
        .wr_data_i (bus.in_data),
        .rd_en_i   (w_rd_en),
        .rd_data_o (w_rd_data),
        .level_o   (w_level)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ing_state_q    <= ING_WAIT;
            tx_state_q     <= TX_IDLE;
            wr_cnt_q       <= '0;
            tx_cnt_q       <= '0;
            frames_ready_q <= '0;
            drop_cnt_q     <= '0;
            proto_err_q    <= 1'b0;
        end else begin
            ing_state_q    <= ing_state_d;
            tx_state_q     <= tx_state_d;
            wr_cnt_q       <= wr_cnt_d;
            tx_cnt_q       <= tx_cnt_d;
            frames_ready_q <= frames_ready_d;
            drop_cnt_q     <= drop_cnt_d;
            proto_err_q    <= proto_err_d;
        end
    end

    // Space for a whole frame is reserved at frame_start, so writes can never overflow.
    always_comb begin
        ing_state_d  = ing_state_q;
        wr_cnt_d     = wr_cnt_q;
        drop_cnt_d   = drop_cnt_q;
        proto_err_d  = proto_err_q;
        w_wr_en      = 1'b0;
        w_frame_done = 1'b0;
        w_free       = c_DEPTH - w_level;
        w_fits       = (w_free >= c_FRAME_WORDS);

        case (ing_state_q)
            ING_WAIT: begin
                if (bus.in_frame_start) begin
                    if (w_fits) begin
                        ing_state_d = ING_COLLECT;
                        w_wr_en     = bus.in_valid;
                    end else if (drop_cnt_q != '1) begin
                        drop_cnt_d = drop_cnt_q + 1'b1;
                    end
                end
            end
            ING_COLLECT: begin
                w_wr_en = bus.in_valid;
                if (bus.in_frame_start) begin
                    proto_err_d = 1'b1;
                end
            end
            default: ing_state_d = ING_WAIT;
        endcase

        if (w_wr_en) begin
            if (wr_cnt_q == c_LAST_BEAT) begin
                w_frame_done = 1'b1;
                wr_cnt_d     = '0;
                ing_state_d  = ING_WAIT;
            end else begin
                wr_cnt_d = wr_cnt_q + 1'b1;
            end
        end
    end

    // The RAM read register doubles as the output register: an accepted beat
    // fetches the next word on the same edge, giving back-to-back beats.
    always_comb begin
        tx_state_d   = tx_state_q;
        tx_cnt_d     = tx_cnt_q;
        w_rd_en      = 1'b0;
        w_eop_accept = 1'b0;

        case (tx_state_q)
            TX_IDLE: begin
                if (frames_ready_q != '0) begin
                    tx_state_d = TX_LOAD;
                end
            end
            TX_LOAD: begin
                w_rd_en    = 1'b1;
                tx_cnt_d   = '0;
                tx_state_d = TX_SEND;
            end
            TX_SEND: begin
                if (bus.out_ready) begin
                    if (tx_cnt_q == c_LAST_BEAT) begin
                        w_eop_accept = 1'b1;
                        tx_state_d   = TX_IDLE;
                    end else begin
                        w_rd_en  = 1'b1;
                        tx_cnt_d = tx_cnt_q + 1'b1;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase

        frames_ready_d = frames_ready_q;
        case ({w_frame_done, w_eop_accept})
            2'b10:   frames_ready_d = frames_ready_q + 1'b1;
            2'b01:   frames_ready_d = frames_ready_q - 1'b1;
            default: frames_ready_d = frames_ready_q;
        endcase
    end

`ifdef INVERT_DATA_EN
    assign w_word = ~w_rd_data;
`else
    assign w_word = w_rd_data;
`endif

    assign bus.out_valid         = (tx_state_q == TX_SEND);
    assign bus.out_startofpacket = bus.out_valid && (tx_cnt_q == '0);
    assign bus.out_endofpacket   = bus.out_valid && (tx_cnt_q == c_LAST_BEAT);
    assign bus.out_data          = bus.out_valid ? w_word : '0;
    assign bus.out_empty         = '0;

    assign frame_drop_cnt = drop_cnt_q;
    assign proto_err      = proto_err_q;
    assign busy           = (ing_state_q == ING_COLLECT) || (frames_ready_q != '0)
                            || (tx_state_q != TX_IDLE);

endmodule
`default_nettype wire
